// File: rtl/cve2_pkg.sv
// Shared types for the OBI memory arbiter: who owns a transaction, and the arbiter FSM states.
package cve2_pkg;

    typedef enum logic {ARB_OWNER_INSTR, ARB_OWNER_DATA} arb_owner_e;
    typedef enum logic {ARB_ST_ARB, ARB_ST_HOLD} arb_state_e;

    localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/cve2_arb_owner_fifo.sv
// Small synchronous FIFO recording which port owns each granted-but-unanswered transaction.
// Depth need not be a power of two; pointers wrap explicitly at Depth.
module cve2_arb_owner_fifo
    import cve2_pkg::*;
#(
    parameter int Depth = 2,
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  arb_owner_e      wdata_i,
    output arb_owner_e      rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    arb_owner_e      mem_q [Depth];
    arb_owner_e      mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= ARB_OWNER_INSTR;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cve2_obi_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and LSU, with a cap on outstanding
// transactions, starvation protection for fetch, and in-order response routing.
module cve2_obi_mem_arbiter
    import cve2_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int StarveLimit    = 4,
    parameter bit DataPriority   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        idle_o,
    output logic        orphan_rsp_o
);

    localparam int CntW    = $clog2(MaxOutstanding + 1);
    localparam int StarveW = $clog2(StarveLimit + 1);

    // OBI handshake: a transfer happens in the cycle where req and gnt are both high; once
    // req is raised the requester holds req and payload unchanged until that cycle. Each
    // transfer is answered later by exactly one rvalid, in issue order.

    arb_state_e         state_q, state_d;
    arb_owner_e         owner_q, owner_d;
    arb_owner_e         sel_owner, head_owner;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [CntW-1:0]    out_count;
    logic               sel_req, starved, slot_free;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign starved   = (starve_q >= StarveW'(StarveLimit));
    assign fifo_pop  = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign slot_free = ~fifo_full | fifo_pop;

    always_comb begin
        sel_owner = ARB_OWNER_INSTR;
        sel_req   = 1'b0;
        if (state_q == ARB_ST_HOLD) begin
            sel_owner = owner_q;
            sel_req   = (owner_q == ARB_OWNER_DATA) ? data_req_i : instr_req_i;
        end else if (instr_req_i && data_req_i) begin
            sel_req   = 1'b1;
            sel_owner = (DataPriority && !starved) ? ARB_OWNER_DATA : ARB_OWNER_INSTR;
        end else if (data_req_i) begin
            sel_req   = 1'b1;
            sel_owner = ARB_OWNER_DATA;
        end else if (instr_req_i) begin
            sel_req   = 1'b1;
            sel_owner = ARB_OWNER_INSTR;
        end
    end

    assign mem_req_o   = sel_req & slot_free & ~rst_i;
    assign fifo_push   = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = fifo_push & (sel_owner == ARB_OWNER_INSTR);
    assign data_gnt_o  = fifo_push & (sel_owner == ARB_OWNER_DATA);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel_owner == ARB_OWNER_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = INSTR_BE;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_ST_ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = ARB_ST_HOLD;
                    owner_d = sel_owner;
                end
            end
            ARB_ST_HOLD: begin
                if (fifo_push || !sel_req) begin
                    state_d = ARB_ST_ARB;
                end
            end
            default: state_d = ARB_ST_ARB;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) begin
            starve_d = '0;
        end else if (data_gnt_o && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_ST_ARB;
            owner_q  <= ARB_OWNER_INSTR;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    cve2_arb_owner_fifo #(
        .Depth(MaxOutstanding)
    ) u_owner_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .wdata_i(sel_owner),
        .rdata_o(head_owner),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(out_count)
    );

    assign instr_rvalid_o = fifo_pop & (head_owner == ARB_OWNER_INSTR);
    assign data_rvalid_o  = fifo_pop & (head_owner == ARB_OWNER_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign orphan_rsp_o   = mem_rvalid_i & fifo_empty & ~rst_i;
    assign idle_o         = (out_count == '0) & ~mem_req_o;

endmodule

// File: tb/tb_cve2_obi_mem_arbiter.sv
// Bench for cve2_obi_mem_arbiter: directed scenarios followed by random OBI traffic, all
// checked each cycle against a queue-based reference model.
module tb_cve2_obi_mem_arbiter;
  localparam int MAXO = 2;
  localparam int SL   = 4;
  localparam bit DP   = 1'b1;

  logic clk = 1'b0;
  logic rst;
  logic instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0] data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic idle, orphan;

  always #5 clk = ~clk;

  cve2_obi_mem_arbiter #(.MaxOutstanding(MAXO), .StarveLimit(SL), .DataPriority(DP)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .idle_o(idle), .orphan_rsp_o(orphan)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: queue of owners (0 = instr, 1 = data) answered in order, the port
  // whose request has been chosen but not yet accepted (-1 none), and the starvation tally.
  int q[$];
  int nq[$];
  int starve_m = 0, n_starve = 0;
  int hold_m = -1, n_hold = -1;
  logic e_ig, e_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Evaluate the current cycle's inputs against the model and compare every output.
  task automatic settle();
    int own;
    logic want, pop, req, e_we, e_irv, e_drv, e_idle, e_orph;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wdata;
    #3;
    own = 0; want = 1'b0; pop = 1'b0; req = 1'b0;
    e_ig = 1'b0; e_dg = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_orph = 1'b0;
    e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    e_idle = (q.size() == 0);
    nq = q;
    if (rst) begin
      nq.delete();
      n_starve = 0;
      n_hold = -1;
    end else begin
      pop = mem_rvalid && (q.size() > 0);
      e_orph = mem_rvalid && (q.size() == 0);
      if (hold_m >= 0) begin
        own = hold_m;
        want = (own == 1) ? data_req : instr_req;
      end else if (instr_req && data_req) begin
        want = 1'b1;
        own = (starve_m >= SL) ? 0 : (DP ? 1 : 0);
      end else if (data_req) begin
        want = 1'b1;
        own = 1;
      end else begin
        want = instr_req;
        own = 0;
      end
      req = want && ((q.size() < MAXO) || pop);
      e_ig = req && mem_gnt && (own == 0);
      e_dg = req && mem_gnt && (own == 1);
      if (req) begin
        if (own == 1) begin
          e_we = data_we; e_be = data_be; e_addr = data_addr; e_wdata = data_wdata;
        end else begin
          e_be = 4'hF; e_addr = instr_addr;
        end
      end
      if (pop) begin
        e_irv = (q[0] == 0);
        e_drv = (q[0] == 1);
        void'(nq.pop_front());
      end
      if (req && mem_gnt) nq.push_back(own);
      e_idle = (q.size() == 0) && !req;
      if (req && mem_gnt) n_hold = -1;
      else if (hold_m >= 0 && want) n_hold = hold_m;
      else if (req) n_hold = own;
      else n_hold = -1;
      if (!instr_req || e_ig) n_starve = 0;
      else if (e_dg && starve_m < SL) n_starve = starve_m + 1;
      else n_starve = starve_m;
    end
    chk("mem_req", mem_req, req);
    chk("mem_we", mem_we, e_we);
    chk("mem_be", mem_be, e_be);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("instr_gnt", instr_gnt, e_ig);
    chk("data_gnt", data_gnt, e_dg);
    chk("instr_rvalid", instr_rvalid, e_irv);
    chk("instr_rdata", instr_rdata, e_irv ? mem_rdata : 32'h0);
    chk("instr_err", instr_err, e_irv & mem_err);
    chk("data_rvalid", data_rvalid, e_drv);
    chk("data_rdata", data_rdata, e_drv ? mem_rdata : 32'h0);
    chk("data_err", data_err, e_drv & mem_err);
    chk("idle", idle, e_idle);
    chk("orphan", orphan, e_orph);
  endtask

  task automatic tick();
    @(posedge clk);
    q = nq;
    starve_m = n_starve;
    hold_m = n_hold;
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_err = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
      settle();
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    instr_addr = 32'h0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    @(posedge clk);
    #1;
    // Reset state.
    settle();
    chk("reset_idle", idle, 1'b1);
    tick();
    rst = 1'b0;

    // Lone fetch, response next cycle.
    instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
    settle();
    chk("t1_gnt", instr_gnt, 1'b1);
    chk("t1_addr", mem_addr, 32'h100);
    tick();
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("t1_rvalid", instr_rvalid, 1'b1);
    chk("t1_rdata", instr_rdata, 32'hDEADBEEF);
    chk("t1_data_quiet", data_rvalid, 1'b0);
    tick();
    idle_inputs();

    // Both ports always requesting: D,D,D,D,I repeating.
    instr_req = 1'b1; instr_addr = 32'h140;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3; data_addr = 32'h2000; data_wdata = 32'h55AA;
    mem_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mem_rvalid = (k > 0);
      mem_rdata = $urandom;
      settle();
      chk("t2_data_gnt", data_gnt, (k % 5) != 4);
      chk("t2_instr_gnt", instr_gnt, (k % 5) == 4);
      tick();
    end
    drain();

    // Data wins and is held through three refused cycles.
    instr_req = 1'b1; instr_addr = 32'h200;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      mem_gnt = (k == 3);
      settle();
      chk("t3_addr", mem_addr, 32'h300);
      chk("t3_instr_gnt", instr_gnt, 1'b0);
      chk("t3_data_gnt", data_gnt, k == 3);
      tick();
    end
    drain();

    // Outstanding cap, with same-cycle pop releasing a slot.
    instr_req = 1'b1; instr_addr = 32'h400; mem_gnt = 1'b1;
    settle(); tick();
    instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h500;
    settle(); chk("t4_d_gnt", data_gnt, 1'b1); tick();
    data_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h404;
    settle(); chk("t4_capped", mem_req, 1'b0); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1;
    settle();
    chk("t4_irv", instr_rvalid, 1'b1);
    chk("t4_ird", instr_rdata, 32'h1);
    chk("t4_regrant", instr_gnt, 1'b1);
    tick();
    instr_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h2;
    settle();
    chk("t4_drv", data_rvalid, 1'b1);
    chk("t4_drd", data_rdata, 32'h2);
    tick();
    drain();

    // Orphan response.
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    settle();
    chk("t5_orphan", orphan, 1'b1);
    chk("t5_no_irv", instr_rvalid, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("t5_orphan_end", orphan, 1'b0);
    tick();

    // Reset with two outstanding; later responses are orphans.
    instr_req = 1'b1; mem_gnt = 1'b1;
    settle(); tick();
    instr_req = 1'b0; data_req = 1'b1;
    settle(); tick();
    idle_inputs();
    rst = 1'b1;
    settle(); tick();
    rst = 1'b0;
    settle();
    chk("t6_idle", idle, 1'b1);
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      settle();
      chk("t6_orphan", orphan, 1'b1);
      tick();
    end
    idle_inputs();

    // Random OBI-legal traffic.
    for (int c = 0; c < 500; c++) begin
      if (!instr_req || e_ig) begin
        instr_req = $urandom_range(0, 1);
        instr_addr = {$urandom_range(0, 32'hFFFF), 2'b00};
      end
      if (!data_req || e_dg) begin
        data_req = $urandom_range(0, 1);
        data_we = $urandom_range(0, 1);
        data_be = $urandom_range(1, 15);
        data_addr = $urandom;
        data_wdata = $urandom;
      end
      mem_gnt = ($urandom_range(0, 9) < 7);
      mem_rvalid = $urandom_range(0, 1);
      mem_rdata = $urandom;
      mem_err = ($urandom_range(0, 7) == 0);
      rst = (c % 97 == 60);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
